// File: rtl/lc3b_types.sv
// Shared LC-3b types and constants for the performance-counter MMIO window.
package lc3b_types;

    localparam logic [15:0] PERF_BASE     = 16'hFFC0;
    localparam logic [15:0] PERF_WIN_MASK = 16'hFFE0;
    localparam int          PERF_NUM_CTRS = 8;
    localparam logic [4:0]  PERF_OFS_CTRL = 5'h10;
    localparam logic [4:0]  PERF_OFS_SNAP = 5'h12;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } perf_mmio_state_t;

endpackage

// File: rtl/perf_ovf_detect.sv
// Overflow detector for one counter: remembers last value, raises a sticky flag
// on a 0xFFFF -> 0x0000 step; a clear in the same cycle wins over a new wrap.
module perf_ovf_detect (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_count,
    input  logic        i_clear,
    output logic        o_ovf
);

    logic [15:0] r_prev;
    logic        r_ovf;
    logic        w_wrap;

    assign w_wrap = (r_prev == 16'hFFFF) && (i_count == 16'h0000);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 16'h0000;
            r_ovf  <= 1'b0;
        end else begin
            r_prev <= i_count;
            if (i_clear)
                r_ovf <= 1'b0;
            else if (w_wrap)
                r_ovf <= 1'b1;
        end
    end

    assign o_ovf = r_ovf;

endmodule

// File: rtl/perf_counter_mmio.sv
// MMIO window exposing eight performance counters and their overflow flags;
// all other CPU traffic passes straight to the data cache. Option: PERF_SNAPSHOT_EN.
module perf_counter_mmio
    import lc3b_types::*;
#(
    parameter logic [15:0] BASE = PERF_BASE
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [15:0]                      cpu_address,
    input  logic                             cpu_read,
    input  logic                             cpu_write,
    input  logic [15:0]                      cpu_wdata,
    input  logic [1:0]                       cpu_byte_enable,
    output logic                             cpu_resp,
    output logic [15:0]                      cpu_rdata,
    output logic [15:0]                      cache_address,
    output logic                             cache_read,
    output logic                             cache_write,
    output logic [15:0]                      cache_wdata,
    output logic [1:0]                       cache_byte_enable,
    input  logic                             cache_resp,
    input  logic [15:0]                      cache_rdata,
    input  logic [PERF_NUM_CTRS-1:0][15:0]   count_in,
    output logic [PERF_NUM_CTRS-1:0]         ctr_clear
);

    perf_mmio_state_t                r_state;
    logic [15:0]                     r_rdata;
    logic [PERF_NUM_CTRS-1:0]        r_clear;

    logic                            w_hit;
    logic [4:0]                      w_ofs;
    logic [15:0]                     w_rd_val;
    logic [PERF_NUM_CTRS-1:0]        w_clear_req;
    logic [PERF_NUM_CTRS-1:0]        w_ovf;
    logic [PERF_NUM_CTRS-1:0][15:0]  w_ctr_src;

    assign w_hit = (cpu_read || cpu_write) && ((cpu_address & PERF_WIN_MASK) == BASE);
    assign w_ofs = {cpu_address[4:1], 1'b0};

    assign w_clear_req = (cpu_write && cpu_byte_enable[0] && (w_ofs == PERF_OFS_CTRL))
                       ? cpu_wdata[PERF_NUM_CTRS-1:0] : '0;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_rd_val = 16'h0000;
        if (cpu_read && !cpu_write) begin
            if (!w_ofs[4])
                w_rd_val = w_ctr_src[w_ofs[3:1]];
            else if (w_ofs == PERF_OFS_CTRL)
                w_rd_val = {8'h00, w_ovf};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_rdata <= 16'h0000;
            r_clear <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_state <= RESP;
                        r_rdata <= w_rd_val;
                        r_clear <= w_clear_req;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_clear <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Gating on the state lets an async reset in RESP kill the pulse at once.
    assign ctr_clear = (r_state == RESP) ? r_clear : '0;

`ifdef PERF_SNAPSHOT_EN
    logic                            r_snap_req;
    logic [PERF_NUM_CTRS-1:0][15:0]  r_snap;

    // NOTE: the snapshot bank is reset so a read before any capture returns zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap_req <= 1'b0;
            r_snap     <= '0;
        end else if (r_state == IDLE) begin
            r_snap_req <= w_hit && cpu_write && (w_ofs == PERF_OFS_SNAP);
        end else begin
            r_snap_req <= 1'b0;
            if (r_snap_req)
                r_snap <= count_in;
        end
    end

    assign w_ctr_src = r_snap;
`else
    assign w_ctr_src = count_in;
`endif

    for (genvar g = 0; g < PERF_NUM_CTRS; g++) begin : g_ovf
        perf_ovf_detect u_ovf (
            .clk     (clk),
            .reset   (reset),
            .i_count (count_in[g]),
            .i_clear (ctr_clear[g]),
            .o_ovf   (w_ovf[g])
        );
    end

    assign cache_address     = cpu_address;
    assign cache_wdata       = cpu_wdata;
    assign cache_byte_enable = cpu_byte_enable;
    assign cache_read        = cpu_read  && !w_hit;
    assign cache_write       = cpu_write && !w_hit;

    assign cpu_resp  = w_hit ? (r_state == RESP) : cache_resp;
    assign cpu_rdata = w_hit ? r_rdata : cache_rdata;

endmodule

// File: tb/tb_perf_counter_mmio.sv
// Randomized self-checking bench for perf_counter_mmio with a transaction-level
// model of counters, sticky overflow flags and (optionally) the snapshot bank.
module tb_perf_counter_mmio;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [15:0]       cpu_address = '0;
    logic              cpu_read = 1'b0;
    logic              cpu_write = 1'b0;
    logic [15:0]       cpu_wdata = '0;
    logic [1:0]        cpu_byte_enable = '0;
    logic              cpu_resp;
    logic [15:0]       cpu_rdata;
    logic [15:0]       cache_address;
    logic              cache_read;
    logic              cache_write;
    logic [15:0]       cache_wdata;
    logic [1:0]        cache_byte_enable;
    logic              cache_resp = 1'b0;
    logic [15:0]       cache_rdata = '0;
    logic [7:0][15:0]  count = '0;
    logic [7:0]        ctr_clear;

`ifdef PERF_SNAPSHOT_EN
    localparam bit SNAP_EN = 1'b1;
`else
    localparam bit SNAP_EN = 1'b0;
`endif
    localparam logic [15:0] WIN = 16'hFFC0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [15:0] m_last [8];
    logic [15:0] m_snap [8];
    logic [7:0]  m_ovf;
    logic [7:0]  m_clear;
    bit          m_snap_req;

    perf_counter_mmio dut (
        .clk               (clk),
        .reset             (reset),
        .cpu_address       (cpu_address),
        .cpu_read          (cpu_read),
        .cpu_write         (cpu_write),
        .cpu_wdata         (cpu_wdata),
        .cpu_byte_enable   (cpu_byte_enable),
        .cpu_resp          (cpu_resp),
        .cpu_rdata         (cpu_rdata),
        .cache_address     (cache_address),
        .cache_read        (cache_read),
        .cache_write       (cache_write),
        .cache_wdata       (cache_wdata),
        .cache_byte_enable (cache_byte_enable),
        .cache_resp        (cache_resp),
        .cache_rdata       (cache_rdata),
        .count_in          (count),
        .ctr_clear         (ctr_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_last[i] = 16'h0000;
            m_snap[i] = 16'h0000;
        end
        m_ovf      = '0;
        m_clear    = '0;
        m_snap_req = 1'b0;
    endtask

    // One clock edge: advance the model with the counter values seen at the edge.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (m_clear[i])
                    m_ovf[i] = 1'b0;
                else if (m_last[i] == 16'hFFFF && count[i] == 16'h0000)
                    m_ovf[i] = 1'b1;
                m_last[i] = count[i];
                if (m_snap_req)
                    m_snap[i] = count[i];
            end
        end
        #1;
    endtask

    // Full window access; wrap_idx >= 0 drops that counter to 0 during the response cycle.
    task automatic access(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                          input logic [1:0] be, input int wrap_idx, output logic [15:0] rd);
        logic [4:0]  ofs;
        logic [15:0] exp_rd;
        logic [7:0]  exp_clr;
        bit          snap;
        ofs     = addr[4:0] & 5'h1E;
        exp_rd  = 16'h0000;
        if (!wr) begin
            if (ofs < 5'h10)
                exp_rd = SNAP_EN ? m_snap[ofs >> 1] : count[ofs >> 1];
            else if (ofs == 5'h10)
                exp_rd = {8'h00, m_ovf};
        end
        exp_clr = (wr && ofs == 5'h10 && be[0]) ? wd[7:0] : 8'h00;
        snap    = SNAP_EN && wr && (ofs == 5'h12);

        cpu_address = addr; cpu_read = !wr; cpu_write = wr;
        cpu_wdata = wd; cpu_byte_enable = be;
        @(negedge clk);
        check("hit_first_cycle_resp", cpu_resp, 0);
        check("hit_cache_strobes", {cache_read, cache_write}, 0);
        check("hit_first_cycle_clr", ctr_clear, 0);
        step();
        if (wrap_idx >= 0) count[wrap_idx] = 16'h0000;
        @(negedge clk);
        check("hit_resp", cpu_resp, 1);
        check("hit_rdata", cpu_rdata, exp_rd);
        check("hit_clr_pulse", ctr_clear, exp_clr);
        rd = cpu_rdata;
        m_clear = exp_clr; m_snap_req = snap;
        step();
        m_clear = '0; m_snap_req = 1'b0;
        cpu_read = 1'b0; cpu_write = 1'b0;
        @(negedge clk);
        check("after_resp_clr", ctr_clear, 0);
        check("after_resp_resp", cpu_resp, 0);
        step();
    endtask

    task automatic miss_access();
        logic [15:0] addr, wd, crd;
        logic [1:0]  be;
        bit          wr;
        addr = 16'($urandom);
        if ((addr & 16'hFFE0) == WIN) addr = addr ^ 16'h0020;
        wr  = 1'($urandom);
        wd  = 16'($urandom);
        be  = 2'($urandom);
        crd = 16'($urandom);
        cpu_address = addr; cpu_read = !wr; cpu_write = wr;
        cpu_wdata = wd; cpu_byte_enable = be;
        cache_rdata = crd; cache_resp = 1'b1;
        @(negedge clk);
        check("miss_cache_rd", cache_read, !wr);
        check("miss_cache_wr", cache_write, wr);
        check("miss_cache_addr", cache_address, addr);
        check("miss_cache_wdata", {cache_byte_enable, cache_wdata}, {be, wd});
        check("miss_resp", cpu_resp, 1);
        check("miss_rdata", cpu_rdata, crd);
        check("miss_clr", ctr_clear, 0);
        cache_resp = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
        step();
    endtask

    task automatic perturb();
        for (int i = 0; i < 8; i++) begin
            case ($urandom % 8)
                0: count[i] = 16'hFFFF;
                1: count[i] = count[i] + 16'd1;
                2: count[i] = 16'($urandom);
                3, 4: if (count[i] == 16'hFFFF) count[i] = 16'h0000;
                default: ;
            endcase
        end
    endtask

    initial begin
        logic [15:0] rd;
        model_reset();

        // Reset state with a hit request held
        reset = 1'b1;
        cpu_address = 16'hFFD0; cpu_read = 1'b1;
        step(); step();
        @(negedge clk);
        check("rst_hit_resp", cpu_resp, 0);
        check("rst_clr", ctr_clear, 0);
        check("rst_cache_rd", cache_read, 0);
        cpu_read = 1'b0;
        step();
        reset = 1'b0;
        step();

        // Miss pass-through with 0x1234 at the cache
        cache_rdata = 16'h1234; cpu_address = 16'hFF00; cpu_read = 1'b1;
        @(negedge clk);
        check("miss_ff00_cache_rd", cache_read, 1);
        check("miss_ff00_no_resp", cpu_resp, 0);
        cache_resp = 1'b1;
        #1;
        check("miss_ff00_resp", cpu_resp, 1);
        check("miss_ff00_rdata", cpu_rdata, 16'h1234);
        cache_resp = 1'b0; cpu_read = 1'b0;
        step();

        // Counter read with one-cycle latency
        count[3] = 16'h00AB;
        step();
        access(1'b0, 16'hFFC6, 16'h0000, 2'b00, -1, rd);
        check("ctr3_read", rd, 16'h00AB);

        // Overflow of counter 5
        count[5] = 16'hFFFF; step();
        count[5] = 16'h0000; step();
        access(1'b0, 16'hFFD0, 16'h0000, 2'b00, -1, rd);
        check("ovf5_read", rd, 16'h0020);

        // Clear write racing a new wrap on counter 5
        count[5] = 16'hFFFF; step();
        access(1'b1, 16'hFFD0, 16'h0021, 2'b01, 5, rd);
        check("clr_write_rdata", rd, 16'h0000);
        access(1'b0, 16'hFFD0, 16'h0000, 2'b00, -1, rd);
        check("ovf_after_clear", rd, 16'h0000);

        // Snapshot vs live read of counter 0
        count[0] = 16'h0010; step();
        access(1'b1, 16'hFFD2, 16'hBEEF, 2'b11, -1, rd);
        count[0] = 16'h0050; step();
        access(1'b0, 16'hFFC0, 16'h0000, 2'b00, -1, rd);
        check("snap_ctr0", rd, SNAP_EN ? 16'h0010 : 16'h0050);

        // Reset during the response cycle of a clear write
        count[5] = 16'hFFFF; step();
        count[5] = 16'h0000; step();
        cpu_address = 16'hFFD0; cpu_write = 1'b1; cpu_wdata = 16'h00FF; cpu_byte_enable = 2'b01;
        @(negedge clk);
        step();
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_in_resp_resp", cpu_resp, 0);
        check("rst_in_resp_clr", ctr_clear, 0);
        step();
        cpu_write = 1'b0;
        step();
        reset = 1'b0;
        step();
        access(1'b0, 16'hFFD0, 16'h0000, 2'b00, -1, rd);
        check("rst_in_resp_ovf", rd, 16'h0000);

        // Randomized traffic
        for (int it = 0; it < 150; it++) begin
            int          n_idle;
            int          wrap_idx;
            int          cand[$];
            logic [4:0]  ofs;
            n_idle = $urandom_range(0, 2);
            for (int k = 0; k < n_idle; k++) begin
                perturb();
                step();
            end
            if ($urandom % 8 == 0) begin
                miss_access();
            end else begin
                ofs = 5'($urandom);
                if ($urandom % 3 == 0) ofs = 5'h10 + 5'($urandom % 4);
                wrap_idx = -1;
                for (int i = 0; i < 8; i++)
                    if (count[i] == 16'hFFFF) cand.push_back(i);
                if (cand.size() > 0 && ($urandom % 2 == 1))
                    wrap_idx = cand[$urandom_range(0, cand.size() - 1)];
                access(1'($urandom), WIN | {11'd0, ofs}, 16'($urandom), 2'($urandom), wrap_idx, rd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
